// File: rtl/spi_reg_pkg.sv
// Shared constants, reset values, FSM state type and the volume slew helper
// for the SPI register commit path.
package spi_reg_pkg;

  // Register map of spi_rx_registers
  localparam logic [7:0] ADDR_CONTROL = 8'h00;
  localparam logic [7:0] ADDR_FREQ_L  = 8'h02;
  localparam logic [7:0] ADDR_FREQ_M  = 8'h03;
  localparam logic [7:0] ADDR_FREQ_H  = 8'h04;
  localparam logic [7:0] ADDR_DUTY    = 8'h05;
  localparam logic [7:0] ADDR_VOLUME  = 8'h06;
  localparam logic [7:0] ADDR_STATUS  = 8'h12;

  // Control register bit positions
  localparam int CTRL_OSC_EN = 0;

  // Values the datapath sees out of reset
  localparam logic [7:0]  RST_CONTROL = 8'h00;
  localparam logic [23:0] RST_FREQ    = 24'h000000;
  localparam logic [7:0]  RST_DUTY    = 8'h80;
  localparam logic [7:0]  RST_VOLUME  = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_state_e;

  // One slew step of cur toward tgt; snaps when within step. Done in 9 bits
  // so the result can never wrap past 0 or 255.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] diff;
    logic [8:0] res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff <= {1'b0, step}) begin
        res = {1'b0, tgt};
      end else begin
        res = {1'b0, cur} + {1'b0, step};
      end
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff <= {1'b0, step}) begin
        res = {1'b0, tgt};
      end else begin
        res = {1'b0, cur} - {1'b0, step};
      end
    end
    return res[7:0];
  endfunction

endpackage

// File: rtl/spi_reg_commit_vol_ramp.sv
// Slew-limited volume: a free-running divider paces steps of the output
// toward the most recently loaded target.
module vol_ramp
  import spi_reg_pkg::*;
#(
  parameter int RAMP_DIV = 256,
  parameter int VOL_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       target_load,
  input  logic [7:0] target,
  output logic [7:0] vol_out
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [7:0] STEP = 8'(VOL_STEP);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       vol_q, vol_d;
  logic             tick_s;

  // Divider tick, target capture and one slew step per tick
  always_comb begin
    tick_s   = (div_q == DIV_LAST);
    div_d    = div_q + DIV_W'(1);
    target_d = target_q;
    vol_d    = vol_q;
    if (tick_s) begin
      div_d = '0;
      vol_d = slew_toward(vol_q, target_q, STEP);
    end else begin
      vol_d = vol_q;
    end
    if (target_load) begin
      target_d = target;
    end else begin
      target_d = target_q;
    end
  end

  // Ramp state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      target_q <= RST_VOLUME;
      vol_q    <= RST_VOLUME;
    end else begin
      div_q    <= div_d;
      target_q <= target_d;
      vol_q    <= vol_d;
    end
  end

  assign vol_out = vol_q;

endmodule

// File: rtl/spi_reg_commit.sv
// Stages the shadow registers at the end of each SPI transaction and applies
// them to the oscillator atomically at a phase wrap, on timeout, or at once
// when the oscillator is stopped.
module spi_reg_commit
  import spi_reg_pkg::*;
#(
  parameter int WRAP_TIMEOUT = 65535,
  parameter int RAMP_DIV     = 256,
  parameter int VOL_STEP     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic [7:0]  sh_control,
  input  logic [23:0] sh_freq,
  input  logic [7:0]  sh_duty,
  input  logic [7:0]  sh_volume,
  input  logic        phase_wrap,
  output logic [7:0]  act_control,
  output logic [23:0] act_freq,
  output logic [7:0]  act_duty,
  output logic [7:0]  act_volume,
  output logic        commit_pulse,
  output logic        pending
);

  localparam int CNT_W = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRAP_TIMEOUT - 1);

  logic              cs_meta_q, cs_sync_q, cs_prev_q;
  logic              cs_end_s, commit_s;
  commit_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        stg_control_q, stg_control_d;
  logic [23:0]       stg_freq_q, stg_freq_d;
  logic [7:0]        stg_duty_q, stg_duty_d;
  logic [7:0]        stg_volume_q, stg_volume_d;
  logic [7:0]        act_control_q, act_control_d;
  logic [23:0]       act_freq_q, act_freq_d;
  logic [7:0]        act_duty_q, act_duty_d;
  logic              commit_pulse_q;

  assign cs_end_s = cs_sync_q & ~cs_prev_q;

  // Chip-select synchronizer plus previous-value flop for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      cs_meta_q <= spi_cs;
      cs_sync_q <= cs_meta_q;
      cs_prev_q <= cs_sync_q;
    end
  end

  // Next state, timeout counter and commit decision
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_end_s) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (phase_wrap || (cnt_q == CNT_LAST) ||
            !act_control_q[CTRL_OSC_EN] || !stg_control_q[CTRL_OSC_EN]) begin
          commit_s = 1'b1;
          if (cs_end_s) begin
            // Fresh snapshot arrives as the old one commits: re-arm from zero
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // A restage while armed keeps the running count to bound latency
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Staging capture on cs_end and atomic load of the active registers
  always_comb begin
    stg_control_d = stg_control_q;
    stg_freq_d    = stg_freq_q;
    stg_duty_d    = stg_duty_q;
    stg_volume_d  = stg_volume_q;
    act_control_d = act_control_q;
    act_freq_d    = act_freq_q;
    act_duty_d    = act_duty_q;
    if (cs_end_s) begin
      stg_control_d = sh_control;
      stg_freq_d    = sh_freq;
      stg_duty_d    = sh_duty;
      stg_volume_d  = sh_volume;
    end else begin
      stg_control_d = stg_control_q;
    end
    if (commit_s) begin
      act_control_d = stg_control_q;
      act_freq_d    = stg_freq_q;
      act_duty_d    = stg_duty_q;
    end else begin
      act_control_d = act_control_q;
    end
  end

  // FSM, staging and active register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      stg_control_q  <= RST_CONTROL;
      stg_freq_q     <= RST_FREQ;
      stg_duty_q     <= RST_DUTY;
      stg_volume_q   <= RST_VOLUME;
      act_control_q  <= RST_CONTROL;
      act_freq_q     <= RST_FREQ;
      act_duty_q     <= RST_DUTY;
      commit_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stg_control_q  <= stg_control_d;
      stg_freq_q     <= stg_freq_d;
      stg_duty_q     <= stg_duty_d;
      stg_volume_q   <= stg_volume_d;
      act_control_q  <= act_control_d;
      act_freq_q     <= act_freq_d;
      act_duty_q     <= act_duty_d;
      commit_pulse_q <= commit_s;
    end
  end

  vol_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .VOL_STEP (VOL_STEP)
  ) u_vol_ramp (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_load (commit_s),
    .target      (stg_volume_q),
    .vol_out     (act_volume)
  );

  assign act_control  = act_control_q;
  assign act_freq     = act_freq_q;
  assign act_duty     = act_duty_q;
  assign commit_pulse = commit_pulse_q;
  assign pending      = (state_q == ST_ARMED);

endmodule

// File: doc/spi_reg_commit.md
# spi_reg_commit

Commit controller between `spi_rx_registers` and the oscillator core. It takes the shadow register values that `spi_rx_registers` updates byte-by-byte and stages a snapshot when each SPI transaction ends. The snapshot is applied to the synth datapath atomically at a safe point: an oscillator phase wrap, a timeout, or immediately when the oscillator is stopped. This prevents torn 24-bit frequency words and mid-cycle duty changes. Volume changes are slew-limited to avoid clicks.

## Interface
- `WRAP_TIMEOUT`, 65535: clocks spent ARMED before a forced commit.
- `RAMP_DIV`, 256: clocks between volume ramp steps.
- `VOL_STEP`, 1: volume change per ramp step.

- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `spi_cs`  in  1  raw SPI chip select, active low, asynchronous to `clk`.
- `sh_control`  in  8  shadow control register; bit0 = OSC_EN.
- `sh_freq`  in  24  shadow frequency, {high, mid, low}.
- `sh_duty`  in  8  shadow duty cycle.
- `sh_volume`  in  8  shadow volume.
- `phase_wrap`  in  1  one-clock strobe from the oscillator at phase accumulator wrap.
- `act_control`  out  8  committed control value.
- `act_freq`  out  24  committed frequency.
- `act_duty`  out  8  committed duty cycle.
- `act_volume`  out  8  ramped volume fed to the output stage.
- `commit_pulse`  out  1  one-clock pulse after each commit.
- `pending`  out  1  high while a staged snapshot awaits commit.

## Operation
- **CS handling.** `spi_cs` passes through a 2-flop synchronizer. A rising edge on the synchronized value produces the one-clock `cs_end` pulse.
- **Staging.** On `cs_end`, all `sh_*` inputs are captured into staging registers, regardless of which registers the transaction actually wrote.
- **FSM states:** IDLE and ARMED.
  - IDLE → ARMED on `cs_end`. The timeout counter clears to 0.
  - ARMED → IDLE with a commit when any of the following holds:
    - `phase_wrap` = 1;
    - the timeout counter = `WRAP_TIMEOUT`−1;
    - `act_control[0]` = 0 (oscillator stopped, so there is no safe point to wait for);
    - staged `control[0]` = 0.
  - Otherwise the counter increments while ARMED.
- **Commit.** `act_control`, `act_freq` and `act_duty` load from staging, and the volume target loads staged volume. `commit_pulse` is 1 on the following cycle.
- **Boundary conditions:**
  - `cs_end` while ARMED: staging is overwritten with the new snapshot, the FSM stays ARMED, and the timeout counter is NOT restarted. This bounds the latency from the first pending write.
  - `cs_end` in the same cycle as a commit: the commit uses the old staging. The new snapshot is captured and the FSM goes to ARMED with the counter at 0.
  - `phase_wrap` in IDLE is ignored.
- **Volume ramp.** A divider counts `RAMP_DIV` clocks. On each tick, `act_volume` moves toward the target by `VOL_STEP`. If |target − act_volume| ≤ `VOL_STEP`, it snaps to the target. Arithmetic is done in 9 bits, so there is no wrap past 0 or 255. The ramp runs independently of the FSM, and a new target mid-ramp redirects it from the current value.
- **Reset.** Applies at any time, including mid-ARMED or mid-ramp. The staged snapshot is discarded, and the synchronizer flops reset to 1 (CS idle).

## Timing
- **Reset values:**
  - `act_control` = 0x00;
  - `act_freq` = 0x000000;
  - `act_duty` = 0x80;
  - `act_volume` = 0x00, with target 0x00;
  - `commit_pulse` = 0 and `pending` = 0;
  - FSM = IDLE, all counters = 0.
- **CS edge to `cs_end`:** the `cs_end` pulse is high in clock edge 2 after the first edge that samples `spi_cs` high.
- **`pending`:** equals (state == ARMED) and is registered.
- **Commit latency.** The commit occurs on the clock edge where the commit condition is sampled true. `act_*` are valid from that edge, and `commit_pulse` is high for exactly the next cycle.
- **Worst-case latency** from `cs_end` to commit: `WRAP_TIMEOUT` + 1 clocks.
- **Full-scale ramp time:** 255/`VOL_STEP` × `RAMP_DIV` clocks, which is about 1.3 ms at 50 MHz with defaults.

## Structure
- **Package `spi_reg_pkg`:**
  - register address constants (0x00, 0x02–0x06, status 0x12);
  - `CTRL_OSC_EN` bit index = 0;
  - reset values (duty 0x80);
  - FSM state typedef {IDLE, ARMED}.
- **Sub-module `vol_ramp`:** holds the divider, target register and slew logic. Its ports are `clk`, `rst_n`, `target_load`, `target[7:0]` and `vol_out[7:0]`.
- **Top level:** the synchronizer, edge detect, staging registers, FSM and timeout counter stay in `spi_reg_commit`.

## Test plan
- **Atomic frequency.** Set `act_control` = 0x01 (oscillator running) and drive no `phase_wrap`. Drive `sh_freq` = 0x024000, then raise `spi_cs` → `pending` = 1 and `act_freq` unchanged. Pulse `phase_wrap` → `act_freq` = 0x024000 and `commit_pulse` high for 1 cycle.
- **Oscillator stopped.** With `act_control` = 0x00, `cs_end` with `sh_control` = 0x1D → commit in the first ARMED cycle, `act_control` = 0x1D.
- **Timeout.** Set `WRAP_TIMEOUT` = 16, oscillator running, no `phase_wrap` → commit exactly 16 clocks after entering ARMED.
- **Restage.** Two CS ends 5 clocks apart with `sh_duty` 0x40 then 0x60, then `phase_wrap` → `act_duty` = 0x60 and a single `commit_pulse`. With `WRAP_TIMEOUT` = 16, the forced commit occurs 16 clocks after the first `cs_end` path.
- **Volume ramp.** Set `RAMP_DIV` = 4 and commit volume 0x08 from 0x00 → `act_volume` steps +1 every 4 clocks and reaches 0x08 after 32 clocks. Committing 0x00 mid-ramp reverses the ramp without underflow.
- **Reset mid-ARMED.** Assert `rst_n` low → all outputs return to their reset values immediately. After release, no commit occurs from a `phase_wrap`.
